// File: rtl/ascon_pkg.sv
// Ascon shared types, constants and helpers.
// Used by the permutation engine and its round datapath.
package ascon_pkg;

  localparam int ASCON_MAX_ROUNDS = 12;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } state_t;

  typedef enum logic {
    IDLE,
    BUSY
  } ascon_perm_fsm_t;

  // Round constant: high nibble 15-i, low nibble i.
  function automatic logic [7:0] ascon_rc(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

  function automatic logic [63:0] ror64(
    input logic [63:0] v,
    input int unsigned n
  );
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_perm_if.sv
// Handshake and state bus between the mode controller
// and the Ascon permutation engine.
interface ascon_perm_if;
  import ascon_pkg::*;

  logic       start_i;
  logic [3:0] rounds_i;
  logic       abort_i;
  state_t     state_i;
  logic       ready_o;
  logic       busy_o;
  logic       valid_o;
  state_t     state_o;
  logic       intr_o;

  modport master (
    output start_i, rounds_i, abort_i, state_i,
    input  ready_o, busy_o, valid_o, state_o, intr_o
  );

  modport slave (
    input  start_i, rounds_i, abort_i, state_i,
    output ready_o, busy_o, valid_o, state_o, intr_o
  );

endinterface

// File: rtl/ascon_perm_engine_round.sv
// One combinational Ascon round: constant add, sbox layer,
// linear diffusion. Passes the state through when disabled.
module ascon_round
  import ascon_pkg::*;
(
  input  state_t     x_i,
  input  logic [7:0] rc_i,
  input  logic       en_i,
  output state_t     x_o
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;

  // Bitsliced sbox followed by per-word rotate-xor diffusion.
  always_comb begin
    a0 = x_i.x0;
    a1 = x_i.x1;
    a2 = x_i.x2 ^ {56'd0, rc_i};
    a3 = x_i.x3;
    a4 = x_i.x4;
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    x_o = x_i;
    if (en_i) begin
      x_o.x0 = a0 ^ ror64(a0, 19) ^ ror64(a0, 28);
      x_o.x1 = a1 ^ ror64(a1, 61) ^ ror64(a1, 39);
      x_o.x2 = a2 ^ ror64(a2, 1) ^ ror64(a2, 6);
      x_o.x3 = a3 ^ ror64(a3, 10) ^ ror64(a3, 17);
      x_o.x4 = a4 ^ ror64(a4, 7) ^ ror64(a4, 41);
    end
  end

endmodule

// File: rtl/ascon_perm_engine.sv
// Ascon permutation engine: runs nr rounds on a 320-bit
// state, UNROLL rounds per clock, pulses valid on completion.
module ascon_perm_engine
  import ascon_pkg::*;
#(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = ASCON_MAX_ROUNDS
) (
  input logic          clk_i,
  input logic          rst_n_i,
  ascon_perm_if.slave  bus
);

  if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1..4");
  end

  ascon_perm_fsm_t fsm_q, fsm_d;
  logic [3:0]      ri_q, ri_d;
  state_t          st_q, st_d;
  logic            vld_q, vld_d;

  logic [3:0] nr;
  logic [4:0] ri_nxt;
  logic       last;
  state_t     chain [UNROLL+1];

  assign nr = (bus.rounds_i > 4'(MAX_ROUNDS)) ?
              4'(MAX_ROUNDS) : bus.rounds_i;
  assign ri_nxt = {1'b0, ri_q} + 5'(UNROLL);
  assign last = ri_nxt >= 5'(MAX_ROUNDS);

  assign chain[0] = st_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    logic [4:0] idx;
    assign idx = {1'b0, ri_q} + 5'(g);
    ascon_round u_rnd (
      .x_i  (chain[g]),
      .rc_i (ascon_rc(idx[3:0])),
      .en_i (idx < 5'(MAX_ROUNDS)),
      .x_o  (chain[g+1])
    );
  end

  // Next-state: accept in IDLE, step rounds in BUSY.
  always_comb begin
    fsm_d = fsm_q;
    ri_d  = ri_q;
    st_d  = st_q;
    vld_d = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          st_d = bus.state_i;
          ri_d = 4'(MAX_ROUNDS) - nr;
          if (nr == 4'd0) vld_d = 1'b1;
          else            fsm_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.abort_i) begin
          fsm_d = IDLE;
        end else begin
          st_d = chain[UNROLL];
          if (last) begin
            ri_d  = 4'(MAX_ROUNDS);
            fsm_d = IDLE;
            vld_d = 1'b1;
          end else begin
            ri_d = ri_nxt[3:0];
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fsm_q <= IDLE;
      ri_q  <= '0;
      st_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      ri_q  <= ri_d;
      st_q  <= st_d;
      vld_q <= vld_d;
    end
  end

  assign bus.ready_o = (fsm_q == IDLE);
  assign bus.busy_o  = (fsm_q == BUSY);
  assign bus.valid_o = vld_q;
  assign bus.intr_o  = vld_q;
  assign bus.state_o = st_q;

endmodule
